pipeline_stall_controller: RTL and testbench

Central sequencer for the freeze/flush inputs of the five-stage pipeline registers: PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Resolves three stall/flush sources each cycle, with fixed priority: multi-cycle memory wait, taken branch, ID-stage data hazard.
- Tracks memory wait states with a timeout FSM.
- Keeps saturating stall and flush performance counters.

---
 rtl/pipeline_stall_controller.sv | 148 ++++++++++++++
 tb/tb_pipeline_stall_controller.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_controller.sv
// Freeze/flush sequencer for the five pipeline registers: resolves memory wait, taken branch
// and ID hazard by fixed priority, tracks memory wait timeouts, keeps stall/flush counters.
module pipeline_stall_controller #(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 hazard_detected,
    input  logic                 branch_taken,
    input  logic                 mem_req,
    input  logic                 mem_ready,
    output logic                 freeze_pc,
    output logic                 freeze_if_id,
    output logic                 freeze_id_ex,
    output logic                 freeze_ex_mem,
    output logic                 flush_if_id,
    output logic                 flush_id_ex,
    output logic                 flush_mem_wb,
    output logic                 mem_timeout,
    output logic [CNT_WIDTH-1:0] stall_count,
    output logic [CNT_WIDTH-1:0] flush_count,
    output logic [1:0]           state
);

    localparam int unsigned WaitW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WaitW-1:0] WaitLimit = WaitW'(MEM_TIMEOUT);
    localparam logic [WaitW-1:0] WaitOne   = WaitW'(1);
    localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StMemWait = 2'd1,
        StError   = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [WaitW-1:0]     wait_cnt_q, wait_cnt_d;
    logic                 mem_timeout_q, mem_timeout_d;
    logic [CNT_WIDTH-1:0] stall_count_q, flush_count_q;

    logic mstall;
    logic apply_mem, apply_branch, apply_hazard;

    assign mstall = mem_req & ~mem_ready;

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q;
        apply_mem     = 1'b0;
        apply_branch  = 1'b0;
        apply_hazard  = 1'b0;

        case (state_q)
            StRun: begin
                if (mstall) begin
                    apply_mem  = 1'b1;
                    state_d    = StMemWait;
                    wait_cnt_d = WaitOne;
                end else if (branch_taken) begin
                    apply_branch = 1'b1;
                end else if (hazard_detected) begin
                    apply_hazard = 1'b1;
                end
            end
            StMemWait: begin
                if (!mstall) begin
                    // Access completed: resolve the lower-priority sources as in RUN.
                    state_d    = StRun;
                    wait_cnt_d = '0;
                    if (branch_taken) begin
                        apply_branch = 1'b1;
                    end else if (hazard_detected) begin
                        apply_hazard = 1'b1;
                    end
                end else begin
                    apply_mem = 1'b1;
                    if (wait_cnt_q == WaitLimit) begin
                        state_d       = StError;
                        mem_timeout_d = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WaitOne;
                    end
                end
            end
            StError: begin
                apply_mem = 1'b1;
            end
            default: begin
                state_d = StRun;
            end
        endcase
    end

    always_comb begin
        freeze_pc     = 1'b0;
        freeze_if_id  = 1'b0;
        freeze_id_ex  = 1'b0;
        freeze_ex_mem = 1'b0;
        flush_if_id   = 1'b0;
        flush_id_ex   = 1'b0;
        flush_mem_wb  = 1'b0;
        if (!rst) begin
            if (apply_mem) begin
                freeze_pc     = 1'b1;
                freeze_if_id  = 1'b1;
                freeze_id_ex  = 1'b1;
                freeze_ex_mem = 1'b1;
                flush_mem_wb  = 1'b1;
            end else if (apply_branch) begin
                flush_if_id = 1'b1;
                flush_id_ex = 1'b1;
            end else if (apply_hazard) begin
                freeze_pc    = 1'b1;
                freeze_if_id = 1'b1;
                flush_id_ex  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StRun;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
            // Saturating counters; stalls held in ERROR are not counted.
            if (freeze_pc && (state_q != StError) && (stall_count_q != '1)) begin
                stall_count_q <= stall_count_q + CntOne;
            end
            if (apply_branch && (flush_count_q != '1)) begin
                flush_count_q <= flush_count_q + CntOne;
            end
        end
    end

    assign mem_timeout = mem_timeout_q;
    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;
    assign state       = state_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Self-checking bench: directed scenarios with literal expectations plus randomized stimulus
// compared every cycle against a cycle-count based behavioural model.
module tb_pipeline_stall_controller;

    localparam int unsigned MT = 4;
    localparam int unsigned CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    // {freeze_pc, freeze_if_id, freeze_id_ex, freeze_ex_mem, flush_if_id, flush_id_ex, flush_mem_wb}
    localparam logic [6:0] PatMem    = 7'b1111001;
    localparam logic [6:0] PatBranch = 7'b0000110;
    localparam logic [6:0] PatHazard = 7'b1100010;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic hazard_detected = 1'b0, branch_taken = 1'b0, mem_req = 1'b0, mem_ready = 1'b0;
    logic freeze_pc, freeze_if_id, freeze_id_ex, freeze_ex_mem;
    logic flush_if_id, flush_id_ex, flush_mem_wb, mem_timeout;
    logic [CW-1:0] stall_count, flush_count;
    logic [1:0] state;

    pipeline_stall_controller #(.MEM_TIMEOUT(MT), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .hazard_detected(hazard_detected), .branch_taken(branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .freeze_pc(freeze_pc), .freeze_if_id(freeze_if_id), .freeze_id_ex(freeze_id_ex),
        .freeze_ex_mem(freeze_ex_mem), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .flush_mem_wb(flush_mem_wb), .mem_timeout(mem_timeout),
        .stall_count(stall_count), .flush_count(flush_count), .state(state)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Model: mode 0=run 1=waiting 2=error; waited = stalled cycles in the current access.
    int m_mode = 0, m_waited = 0, m_to = 0, m_stall = 0, m_flush = 0;

    logic [6:0] outs;
    assign outs = {freeze_pc, freeze_if_id, freeze_id_ex, freeze_ex_mem,
                   flush_if_id, flush_id_ex, flush_mem_wb};

    function automatic logic [6:0] model_out(int mode, logic r, logic hz, logic br,
                                             logic rq, logic rd);
        if (r) return 7'b0;
        if (mode == 2 || (rq && !rd)) return PatMem;
        if (br) return PatBranch;
        if (hz) return PatHazard;
        return 7'b0;
    endfunction

    task automatic check(string name, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        logic [6:0] e;
        e = model_out(m_mode, rst, hazard_detected, branch_taken, mem_req, mem_ready);
        if (rst) begin
            m_mode = 0; m_waited = 0; m_to = 0; m_stall = 0; m_flush = 0;
        end else begin
            if (e[6] && m_mode != 2 && m_stall < CMAX) m_stall++;
            if (e == PatBranch && m_flush < CMAX) m_flush++;
            if (m_mode != 2) begin
                if (mem_req && !mem_ready) begin
                    m_waited++;
                    if (m_waited > MT) begin
                        m_mode = 2; m_to = 1;
                    end else begin
                        m_mode = 1;
                    end
                end else begin
                    m_mode = 0; m_waited = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("outputs", int'(outs),
                  int'(model_out(m_mode, rst, hazard_detected, branch_taken, mem_req, mem_ready)));
            check("state", int'(state), m_mode);
            check("mem_timeout", int'(mem_timeout), m_to);
            check("stall_count", int'(stall_count), m_stall);
            check("flush_count", int'(flush_count), m_flush);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(logic hz, logic br, logic rq, logic rd);
        hazard_detected = hz; branch_taken = br; mem_req = rq; mem_ready = rd;
    endtask

    task automatic do_reset();
        set_in(0, 0, 0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        chk_en = 1'b1;
        rst = 1'b0;

        // Idle after reset
        repeat (10) tick();
        @(negedge clk);
        check("idle_outs", int'(outs), 0);
        check("idle_state", int'(state), 0);
        check("idle_stall", int'(stall_count), 0);
        check("idle_flush", int'(flush_count), 0);

        // Single-cycle hazard
        tick();
        set_in(1, 0, 0, 0);
        @(negedge clk);
        check("hazard_outs", int'(outs), int'(PatHazard));
        tick();
        set_in(0, 0, 0, 0);
        check("hazard_stall", int'(stall_count), 1);

        // Branch wins over hazard
        do_reset();
        set_in(1, 1, 0, 0);
        @(negedge clk);
        check("branch_outs", int'(outs), int'(PatBranch));
        tick();
        set_in(0, 0, 0, 0);
        check("branch_flush", int'(flush_count), 1);
        check("branch_stall", int'(stall_count), 0);

        // Three wait cycles, then completion with a taken branch
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_in(0, 0, 1, 0);
            @(negedge clk);
            check("memwait_outs", int'(outs), int'(PatMem));
            tick();
        end
        set_in(0, 1, 1, 1);
        @(negedge clk);
        check("memdone_outs", int'(outs), int'(PatBranch));
        tick();
        set_in(0, 0, 0, 0);
        check("memdone_state", int'(state), 0);
        check("memdone_stall", int'(stall_count), 3);
        check("memdone_flush", int'(flush_count), 1);

        // Timeout into ERROR, then reset recovery
        do_reset();
        set_in(0, 0, 1, 0);
        repeat (4) tick();
        check("pre_timeout_state", int'(state), 1);
        tick();
        check("timeout_state", int'(state), 2);
        check("timeout_flag", int'(mem_timeout), 1);
        set_in(0, 0, 0, 0);
        repeat (3) tick();
        @(negedge clk);
        check("error_outs", int'(outs), int'(PatMem));
        check("error_stall", int'(stall_count), 5);
        rst = 1'b1;
        @(negedge clk);
        check("rst_outs", int'(outs), 0);
        tick();
        rst = 1'b0;
        check("rst_state", int'(state), 0);
        check("rst_flag", int'(mem_timeout), 0);
        check("rst_stall", int'(stall_count), 0);
        check("rst_flush", int'(flush_count), 0);

        // Saturation
        set_in(1, 0, 0, 0);
        repeat (20) tick();
        check("sat_stall", int'(stall_count), 15);
        set_in(0, 0, 0, 0);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            set_in(logic'($urandom_range(0, 3) == 0), logic'($urandom_range(0, 4) == 0),
                   logic'($urandom_range(0, 1)), logic'($urandom_range(0, 2) == 0));
            tick();
        end
        rst = 1'b0;
        set_in(0, 0, 0, 0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
